// File: rtl/led_ctrl_pkg.sv
// Shared mode encodings and default parameter values for the LED mode controller.
package led_ctrl_pkg;

  typedef enum logic [1:0] {
    MODE_PASS  = 2'b00,
    MODE_BLINK = 2'b01,
    MODE_CHASE = 2'b10,
    MODE_COUNT = 2'b11
  } mode_e;

  localparam int unsigned DEF_DEBOUNCE_CYCLES = 4;
  localparam int unsigned DEF_TICK_DIV        = 8;
  localparam int unsigned DEF_HB_TICKS        = 8;

endpackage

// File: rtl/led_mode_ctrl_debounce_bit.sv
// One switch bit: 2-flop synchronizer followed by a stable-run debounce counter.
module debounce_bit
  import led_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic db
);

  logic       sync1_q, sync2_q, db_q;
  logic [7:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      db_q    <= 1'b0;
      cnt_q   <= 8'd0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      if (sync2_q != db_q) begin
        // Accept on the edge the mismatch run reaches DEBOUNCE_CYCLES.
        if (cnt_q == 8'(DEBOUNCE_CYCLES - 1)) begin
          db_q  <= sync2_q;
          cnt_q <= 8'd0;
        end else begin
          cnt_q <= cnt_q + 8'd1;
        end
      end else begin
        cnt_q <= 8'd0;
      end
    end
  end

  assign db = db_q;

endmodule

// File: rtl/led_mode_ctrl.sv
// Debounced switches select an LED pattern (pass, blink, chase, count); heartbeat on user_led.
module led_mode_ctrl
  import led_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned TICK_DIV        = DEF_TICK_DIV,
  parameter int unsigned HB_TICKS        = DEF_HB_TICKS
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] sw_in,
  output logic [3:0] leds,
  output logic       user_led,
  output logic [1:0] mode
);

  logic [3:0] sw_db;

  for (genvar i = 0; i < 4; i++) begin : g_db
    debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce_bit (
      .clk(clk),
      .rst(rst),
      .raw(sw_in[i]),
      .db (sw_db[i])
    );
  end

  mode_e       mode_q, mode_d;
  logic [15:0] tick_cnt_q, tick_cnt_d;
  logic [7:0]  hb_cnt_q, hb_cnt_d;
  logic        hb_q, hb_d;
  logic        phase_q, phase_d;
  logic [3:0]  chase_q, chase_d;
  logic [3:0]  count_q, count_d;
  logic [3:0]  leds_q, leds_d;
  logic        mode_chg, tick;

  always_comb begin
    mode_d     = mode_e'(sw_db[3:2]);
    mode_chg   = (mode_d != mode_q);
    tick       = (tick_cnt_q == 16'(TICK_DIV - 1));
    tick_cnt_d = tick_cnt_q + 16'd1;
    phase_d    = phase_q;
    chase_d    = chase_q;
    count_d    = count_q;
    hb_cnt_d   = hb_cnt_q;
    hb_d       = hb_q;

    // Mode entry reloads the pattern state and swallows a coincident tick.
    if (mode_chg) begin
      tick_cnt_d = 16'd0;
      phase_d    = 1'b1;
      chase_d    = 4'b0001;
      count_d    = 4'd0;
    end else if (tick) begin
      tick_cnt_d = 16'd0;
      phase_d    = ~phase_q;
      chase_d    = sw_db[0] ? {chase_q[0], chase_q[3:1]} : {chase_q[2:0], chase_q[3]};
      count_d    = count_q + 4'd1;
      if (hb_cnt_q == 8'(HB_TICKS - 1)) begin
        hb_cnt_d = 8'd0;
        hb_d     = ~hb_q;
      end else begin
        hb_cnt_d = hb_cnt_q + 8'd1;
      end
    end

    unique case (mode_d)
      MODE_PASS:  leds_d = sw_db;
      MODE_BLINK: leds_d = phase_d ? {2'b00, sw_db[1:0]} : 4'b0000;
      MODE_CHASE: leds_d = chase_d;
      MODE_COUNT: leds_d = count_d;
      default:    leds_d = 4'b0000;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q     <= MODE_PASS;
      tick_cnt_q <= 16'd0;
      hb_cnt_q   <= 8'd0;
      hb_q       <= 1'b0;
      phase_q    <= 1'b0;
      chase_q    <= 4'b0001;
      count_q    <= 4'd0;
      leds_q     <= 4'b0000;
    end else begin
      mode_q     <= mode_d;
      tick_cnt_q <= tick_cnt_d;
      hb_cnt_q   <= hb_cnt_d;
      hb_q       <= hb_d;
      phase_q    <= phase_d;
      chase_q    <= chase_d;
      count_q    <= count_d;
      leds_q     <= leds_d;
    end
  end

  assign leds     = leds_q;
  assign user_led = hb_q;
  assign mode     = mode_q;

endmodule
